// File: rtl/psum_pkg.sv
// psum_pkg: shared definitions for the partial-sum buffer.
//   psum_state_t   : FSM state encoding (IDLE / RUN / DRAIN)
//   PSUM_DATA_WIDTH: default psum word width (IEEE-754 single)
//   PSUM_ADDR_WIDTH: default RAM address width (Depth = 2**AddrWidth)
//   ZERO_WORD      : psum value supplied on a first pass
package psum_pkg;

   localparam int PSUM_DATA_WIDTH = 32;
   localparam int PSUM_ADDR_WIDTH = 10;

   localparam logic [PSUM_DATA_WIDTH-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } psum_state_t;

endpackage

// File: rtl/psum_ram.sv
// psum_ram: simple dual-port RAM, one synchronous write port and one
// synchronous read port (read data registered, valid one cycle after re).
// No read-during-write bypass; callers guarantee distinct addresses.
//   clk   : clock
//   we    : write enable        waddr : write address   wdata : write data
//   re    : read enable         raddr : read address    rdata : registered read data
module psum_ram #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AddrWidth-1:0] waddr,
   input  logic [DataWidth-1:0] wdata,
   input  logic                 re,
   input  logic [AddrWidth-1:0] raddr,
   output logic [DataWidth-1:0] rdata
);

   logic [DataWidth-1:0] mem [0:(2**AddrWidth)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/psum_buffer.sv
// psum_buffer: partial-sum store for the conv-accumulate stage.
// Each pass covers num_points psums. Every accepted accum_request returns the
// stored psum for the next address (zero on a first pass) one cycle later;
// every accepted result is written back to the same address, or on a last
// pass is presented on psum_out one cycle later instead of being stored.
// Optional feature macro: PSUM_RELU_EN -- last-pass outputs pass through a
// float ReLU (sign bit set -> 0, so -0.0 also becomes +0.0).
// Ports:
//   Clk, Rst       : clock, asynchronous active-high reset
//   start          : pulse, begins a pass; num_points/first_pass/last_pass latched
//   num_points     : points in the pass, legal 1..2**AddrWidth
//   first_pass     : pass supplies zeros, RAM not read
//   last_pass      : results go to psum_out, RAM not written
//   accum_request  : one psum wanted
//   accum_out/accum_valid   : returned psum
//   result_in/result_valid  : accumulated sum from the conv stage
//   psum_out/psum_valid     : final sum (last pass only)
//   busy           : FSM not idle
//   done           : one-cycle pulse at pass completion
//   err            : sticky protocol error, cleared only by Rst
module psum_buffer
   import psum_pkg::*;
#(
   parameter int DataWidth = PSUM_DATA_WIDTH,
   parameter int AddrWidth = PSUM_ADDR_WIDTH
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [AddrWidth:0]   num_points,
   input  logic                 first_pass,
   input  logic                 last_pass,
   input  logic                 accum_request,
   output logic [DataWidth-1:0] accum_out,
   output logic                 accum_valid,
   input  logic [DataWidth-1:0] result_in,
   input  logic                 result_valid,
   output logic [DataWidth-1:0] psum_out,
   output logic                 psum_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam logic [AddrWidth:0] DEPTH = {1'b1, {AddrWidth{1'b0}}};

   psum_state_t          state;
   logic [AddrWidth:0]   rd_cnt;
   logic [AddrWidth:0]   wr_cnt;
   logic [AddrWidth:0]   n_pts;
   logic                 first_r;
   logic                 last_r;
   logic                 acc_zero;
   logic [DataWidth-1:0] ram_rdata;

   logic req_ok;
   logic res_ok;
   logic start_ok;
   logic proto_err;

   function automatic logic [DataWidth-1:0] shape_psum(input logic [DataWidth-1:0] v);
`ifdef PSUM_RELU_EN
      return v[DataWidth-1] ? DataWidth'(ZERO_WORD) : v;
`else
      return v;
`endif
   endfunction

   always_comb begin
      req_ok    = accum_request && (state != IDLE) && (rd_cnt != n_pts);
      res_ok    = result_valid  && (state != IDLE) && (wr_cnt != n_pts);
      start_ok  = start && (state == IDLE) && (num_points != '0) && (num_points <= DEPTH);
      proto_err = (accum_request && !req_ok) || (result_valid && !res_ok) ||
                  (start && !start_ok);
   end

   psum_ram #(
      .DataWidth(DataWidth),
      .AddrWidth(AddrWidth)
   ) u_ram (
      .clk  (Clk),
      .we   (res_ok && !last_r),
      .waddr(wr_cnt[AddrWidth-1:0]),
      .wdata(result_in),
      .re   (req_ok && !first_r),
      .raddr(rd_cnt[AddrWidth-1:0]),
      .rdata(ram_rdata)
   );

   // RAM read data is held by the RAM's own register; gating it here keeps
   // accum_out at zero out of reset and while no return is valid.
   assign accum_out = (accum_valid && !acc_zero) ? ram_rdata : DataWidth'(ZERO_WORD);
   assign busy      = (state != IDLE);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state       <= IDLE;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
         n_pts       <= '0;
         first_r     <= 1'b0;
         last_r      <= 1'b0;
         acc_zero    <= 1'b0;
         accum_valid <= 1'b0;
         psum_out    <= '0;
         psum_valid  <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done        <= 1'b0;
         accum_valid <= req_ok;
         psum_valid  <= res_ok && last_r;
         if (proto_err) begin
            err <= 1'b1;
         end
         if (req_ok) begin
            rd_cnt   <= rd_cnt + 1'b1;
            acc_zero <= first_r;
         end
         if (res_ok) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (last_r) begin
               psum_out <= shape_psum(result_in);
            end
         end
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state   <= RUN;
                  rd_cnt  <= '0;
                  wr_cnt  <= '0;
                  n_pts   <= num_points;
                  first_r <= first_pass;
                  last_r  <= last_pass;
               end
            end
            RUN: begin
               if (wr_cnt == n_pts) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else if (rd_cnt == n_pts) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (wr_cnt == n_pts) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_buffer.sv
module tb_psum_buffer;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          start;
   logic [AW:0]   num_points;
   logic          first_pass;
   logic          last_pass;
   logic          accum_request;
   logic [DW-1:0] accum_out;
   logic          accum_valid;
   logic [DW-1:0] result_in;
   logic          result_valid;
   logic [DW-1:0] psum_out;
   logic          psum_valid;
   logic          busy;
   logic          done;
   logic          err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 Clk = ~Clk;

   psum_buffer #(.DataWidth(DW), .AddrWidth(AW)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .start        (start),
      .num_points   (num_points),
      .first_pass   (first_pass),
      .last_pass    (last_pass),
      .accum_request(accum_request),
      .accum_out    (accum_out),
      .accum_valid  (accum_valid),
      .result_in    (result_in),
      .result_valid (result_valid),
      .psum_out     (psum_out),
      .psum_valid   (psum_valid),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset;
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      tick();
   endtask

   task automatic begin_pass(input logic [AW:0] n, input logic f, input logic l);
      start = 1'b1; num_points = n; first_pass = f; last_pass = l;
      tick();
      start = 1'b0; first_pass = 1'b0; last_pass = 1'b0;
   endtask

   task automatic test_reset;
      start = 0; num_points = '0; first_pass = 0; last_pass = 0;
      accum_request = 0; result_in = '0; result_valid = 0;
      do_reset();
      n_cmp++;
      if ({busy, done, err, accum_valid, psum_valid} !== 5'b0 || accum_out !== '0 || psum_out !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b av=%b pv=%b ao=%h po=%h, want all 0",
                  busy, done, err, accum_valid, psum_valid, accum_out, psum_out);
      end
   endtask

   // first pass: zeros returned, results 1.0..4.0 stored
   task automatic test_first_pass;
      logic [DW-1:0] vals [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
      begin_pass(11'd4, 1'b1, 1'b0);
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b want 1", busy); end
      for (int i = 0; i < 4; i++) begin
         accum_request = 1'b1;
         tick();
         n_cmp++;
         if (accum_valid !== 1'b1 || accum_out !== 32'h0) begin
            n_fail++;
            $display("FAIL first_accum[%0d]: got v=%b d=%h want v=1 d=00000000", i, accum_valid, accum_out);
         end
      end
      accum_request = 1'b0;
      tick();
      n_cmp++;
      if (accum_valid !== 1'b0) begin n_fail++; $display("FAIL first_accum_drop: got %b want 0", accum_valid); end
      for (int i = 0; i < 4; i++) begin
         result_valid = 1'b1; result_in = vals[i];
         tick();
      end
      result_valid = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL first_done: got done=%b busy=%b want done=1 busy=0", done, busy);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL first_done_pulse: got %b want 0", done); end
   endtask

   // middle pass, requests overlapped with write-back of new values
   task automatic middle_pass(input string tag,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                              input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
      logic [DW-1:0] exp_r [4];
      logic [DW-1:0] wb    [4];
      exp_r = '{e0, e1, e2, e3};
      wb    = '{w0, w1, w2, w3};
      begin_pass(11'd4, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         accum_request = (c < 4);
         result_valid  = (c > 0);
         result_in     = (c > 0) ? wb[c-1] : '0;
         tick();
         if (c < 4) begin
            n_cmp++;
            if (accum_valid !== 1'b1 || accum_out !== exp_r[c]) begin
               n_fail++;
               $display("FAIL %s_accum[%0d]: got v=%b d=%h want v=1 d=%h", tag, c, accum_valid, accum_out, exp_r[c]);
            end
         end
      end
      accum_request = 1'b0; result_valid = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1 || err !== 1'b0) begin
         n_fail++; $display("FAIL %s_done: got done=%b err=%b want done=1 err=0", tag, done, err);
      end
   endtask

   task automatic test_middle_pass;
      middle_pass("mid", 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
   endtask

   task automatic test_last_pass;
      logic [DW-1:0] rin  [4] = '{32'hC0000000, 32'h3F800000, 32'h80000000, 32'h40000000};
      logic [DW-1:0] rexp [4] = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      logic [DW-1:0] pexp [4];
`ifdef PSUM_RELU_EN
      pexp = '{32'h00000000, 32'h3F800000, 32'h00000000, 32'h40000000};
`else
      pexp = '{32'hC0000000, 32'h3F800000, 32'h80000000, 32'h40000000};
`endif
      begin_pass(11'd4, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         accum_request = 1'b1;
         tick();
         n_cmp++;
         if (accum_valid !== 1'b1 || accum_out !== rexp[i]) begin
            n_fail++; $display("FAIL last_accum[%0d]: got %h want %h", i, accum_out, rexp[i]);
         end
      end
      accum_request = 1'b0;
      for (int i = 0; i < 4; i++) begin
         result_valid = 1'b1; result_in = rin[i];
         tick();
         n_cmp++;
         if (psum_valid !== 1'b1 || psum_out !== pexp[i]) begin
            n_fail++; $display("FAIL last_psum[%0d]: got v=%b d=%h want v=1 d=%h", i, psum_valid, psum_out, pexp[i]);
         end
      end
      result_valid = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1 || psum_valid !== 1'b0) begin
         n_fail++; $display("FAIL last_done: got done=%b pv=%b want done=1 pv=0", done, psum_valid);
      end
      // RAM must still hold the middle-pass values
      middle_pass("rerun", 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
   endtask

   task automatic test_bad_events;
      result_valid = 1'b1; result_in = 32'h3F800000;
      tick();
      result_valid = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || psum_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_result_err: got err=%b pv=%b busy=%b want 1 0 0", err, psum_valid, busy);
      end
      do_reset();
      n_cmp++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
      begin_pass(11'd4, 1'b1, 1'b0);
      accum_request = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      tick();
      accum_request = 1'b0;
      n_cmp++;
      if (accum_valid !== 1'b0 || err !== 1'b1) begin
         n_fail++; $display("FAIL fifth_request: got av=%b err=%b want av=0 err=1", accum_valid, err);
      end
      // exactly four results should complete the pass
      result_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL fifth_wr_cnt: got busy=%b want 1 after 3 results", busy); end
      tick();
      result_valid = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL fifth_done: got %b want 1", done); end
   endtask

   task automatic test_bad_start;
      do_reset();
      begin_pass(11'd2, 1'b1, 1'b0);
      start = 1'b1; num_points = 11'd4;
      tick();
      start = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_start: got err=%b busy=%b want 1 1", err, busy);
      end
      accum_request = 1'b1;
      tick(); tick();
      accum_request = 1'b0;
      result_valid = 1'b1;
      tick(); tick();
      result_valid = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL busy_start_done: got %b want 1 (n stays 2)", done); end
      do_reset();
      begin_pass(11'd0, 1'b1, 1'b0);
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_start: got err=%b busy=%b want 1 0", err, busy);
      end
      do_reset();
      begin_pass(11'd1025, 1'b1, 1'b0);
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL big_start: got err=%b busy=%b want 1 0", err, busy);
      end
      do_reset();
      begin_pass(11'd1024, 1'b1, 1'b0);
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL depth_start: got err=%b busy=%b want 0 1", err, busy);
      end
   endtask

   task automatic test_reset_mid_pass;
      do_reset();
      begin_pass(11'd4, 1'b1, 1'b0);
      accum_request = 1'b1;
      tick();
      result_valid = 1'b1;
      tick(); tick();
      accum_request = 1'b0; result_valid = 1'b0;
      n_cmp++;
      if (accum_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL pre_rst: got av=%b busy=%b want 1 1", accum_valid, busy);
      end
      #2 Rst = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || accum_valid !== 1'b0) begin
         n_fail++; $display("FAIL async_rst: got busy=%b done=%b av=%b want 0 0 0", busy, done, accum_valid);
      end
      tick();
      Rst = 1'b0;
      tick();
      begin_pass(11'd2, 1'b1, 1'b0);
      accum_request = 1'b1;
      tick();
      result_valid = 1'b1; result_in = 32'h3F800000;
      tick();
      accum_request = 1'b0;
      n_cmp++;
      if (accum_valid !== 1'b1 || accum_out !== 32'h0) begin
         n_fail++; $display("FAIL post_rst_accum: got v=%b d=%h want 1 00000000", accum_valid, accum_out);
      end
      tick();
      result_valid = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1 || err !== 1'b0) begin
         n_fail++; $display("FAIL post_rst_done: got done=%b err=%b want 1 0", done, err);
      end
   endtask

   initial begin
      Rst = 1'b1;
      test_reset();
      test_first_pass();
      test_middle_pass();
      test_last_pass();
      test_bad_events();
      test_bad_start();
      test_reset_mid_pass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
